npu_conv_sequencer: RTL and testbench
=====================================

# npu_conv_sequencer

Schedules one convolution layer pass through NPUCore. It walks the feature-map and parameter buffers in pixel → output-group → input-chunk order and issues synchronous-RAM reads. It drives the MAC valids and the per-window `adder_rst`, and emits a tagged `out_valid` once each accumulation window has cleared the MAC pipeline. It sits between the layer-level control and NPUCore, replacing hand-driven stimulus counters.

## Interface
- `PIXELS`, 1024, output pixels per pass (IMG_ROW*IMG_COL)
- `IN_CHUNKS`, 4, 80-bit input beats per pixel (IN_CHANNEL/10)
- `OUT_GROUPS`, 5, 16-lane output groups (OUT_CHANNEL/16)
- `FILL_DELAY`, 10, cycles from last MAC beat of a window to valid `MAC_data_out`
- `FA_W`, 12, fmap address width; `PA_W`, 5, param address width; `PIX_W`, 10; `GRP_W`, 3
- `clk` in 1, clock
- `rstn` in 1, reset: asynchronous, active-low
- `start` in 1, one-cycle request to begin a pass; ignored unless idle
- `hold` in 1, back-pressure: suppresses new reads; in-flight beats continue
- `busy` out 1, high from the cycle after accepted `start` until `done`
- `done` out 1, one-cycle pulse at end of pass
- `fmap_rd_en` out 1, fmap RAM read strobe
- `fmap_rd_addr` out FA_W, equals pixel*IN_CHUNKS+chunk
- `param_rd_en` out 1, param RAM read strobe, identical to `fmap_rd_en`
- `param_rd_addr` out PA_W, equals group*IN_CHUNKS+chunk
- `mac_in_valid` out 1, drives MAC_data_in_valid and MAC_param_in_valid
- `adder_rst` out 1, marks the first beat of an accumulation window (load, not accumulate)
- `out_valid` out 1, MAC_data_out holds a finished 16-lane result
- `out_pixel` out PIX_W, pixel tag of the current `out_valid`
- `out_group` out GRP_W, group tag of the current `out_valid`

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE → RUN on `start`. Counters `chunk`, `group` and `pixel` clear.
- RUN issues one read per cycle when `hold`=0. `chunk` increments, wrapping at IN_CHUNKS-1. On the wrap, `group` increments, wrapping at OUT_GROUPS-1. On the group wrap, `pixel` increments.
- RUN with `hold`=1 issues no read, and all counters freeze.
- RUN → DRAIN when the read for (PIXELS-1, OUT_GROUPS-1, IN_CHUNKS-1) issues.
- DRAIN waits until the delay line is empty, then → DONE.
- DONE asserts `done` for one cycle, then → IDLE.
- `start` in any state other than IDLE is ignored.
- `hold` during DRAIN has no effect.
- Read-to-MAC path is 1 cycle (registered RAM output):
  - `mac_in_valid` = `fmap_rd_en` delayed 1.
  - `adder_rst` = (`rd_en` && chunk==0) delayed 1.
- A 1-cycle beat with `mac_in_valid`=1 and chunk==IN_CHUNKS-1 enters the delay line together with its {pixel, group} tag. It appears on `out_valid`/`out_pixel`/`out_group` exactly FILL_DELAY cycles later.
- A hold gap inside a window keeps the window intact: no `adder_rst` until the next chunk 0.
- Reset values: all outputs 0, state IDLE, delay line cleared.
- Reset mid-pass aborts immediately. There is no `done` and no further `out_valid`.

## Timing
- `start` sampled at cycle T → `busy`=1 and first `rd_en` at T+1.
- First `mac_in_valid` and `adder_rst` at T+2.
- With no hold, `rd_en` is continuous for PIXELS*OUT_GROUPS*IN_CHUNKS cycles.
- First `out_valid` at T+2+(IN_CHUNKS-1)+FILL_DELAY.
- Consecutive `out_valid` pulses are spaced IN_CHUNKS cycles apart with no hold.
- Let L be the cycle of the last `out_valid`. `done` pulses at L+1, and `busy` drops at L+2.
- `start` arriving in the same cycle as `done` is ignored. A new pass needs `start` at L+2 or later.

## Structure
- Package `npu_pkg` holds BEAT_BYTES=10, MAC_LANES=16, the FSM state enum, and the default geometry constants.
- Sub-module `npu_tag_delay`: a FILL_DELAY-deep shift register of {valid, pixel, group}. It is always shifting and has an asynchronous clear. It also provides an `empty` output for DRAIN.

## Test plan
- Small run with PIXELS=2, IN_CHUNKS=4, OUT_GROUPS=5, FILL_DELAY=10:
  - 40 contiguous reads; fmap addresses 0-3 repeated 5×, then 4-7 repeated 5×.
  - Param addresses 0..19 per pixel.
  - 10 `adder_rst` pulses.
  - 10 `out_valid` pulses tagged (0,0)…(0,4),(1,0)…(1,4); first at T+15.
  - `done` at T+52.
- `hold` high for 3 cycles at chunk 2 of (0,1): reads freeze, no extra `adder_rst`, and that tag's `out_valid` slips by 3 cycles.
- `start` pulsed at T+5 and again on the `done` cycle: both ignored, exactly one pass.
- `rstn` low mid-RUN: all outputs 0 next cycle; no `done`; a fresh `start` restarts at address 0.
- Default geometry (1024×5×4): 20480 reads and 5120 `out_valid` pulses; the last one is tagged (1023,4).
- FILL_DELAY=1 with `hold` toggling every cycle: tag alignment holds, and `done` follows the last `out_valid` by 1 cycle.

Source files
------------

// File: rtl/npu_pkg.sv
// Shared constants, default layer geometry and sequencer state encoding for the NPU
// convolution datapath.
package npu_pkg;

   localparam int unsigned BEAT_BYTES = 10;
   localparam int unsigned MAC_LANES  = 16;

   localparam int unsigned DEF_PIXELS     = 1024;
   localparam int unsigned DEF_IN_CHUNKS  = 4;
   localparam int unsigned DEF_OUT_GROUPS = 5;
   localparam int unsigned DEF_FILL_DELAY = 10;
   localparam int unsigned DEF_FA_W       = 12;
   localparam int unsigned DEF_PA_W       = 5;
   localparam int unsigned DEF_PIX_W      = 10;
   localparam int unsigned DEF_GRP_W      = 3;

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StDrain,
      StDone
   } seq_state_e;

   // Counter width that stays legal for a single-entry range.
   function automatic int unsigned clog2_min1(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/npu_tag_delay.sv
// Fixed-latency shift register carrying {valid, pixel, group} tags alongside the MAC fill
// pipeline; free-running, asynchronously cleared.
module npu_tag_delay #(
   parameter int unsigned FILL_DELAY = 10,
   parameter int unsigned PIX_W      = 10,
   parameter int unsigned GRP_W      = 3
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             valid_i,
   input  logic [PIX_W-1:0] pixel_i,
   input  logic [GRP_W-1:0] group_i,
   output logic             valid_o,
   output logic [PIX_W-1:0] pixel_o,
   output logic [GRP_W-1:0] group_o,
   output logic             empty_o
);

   logic [FILL_DELAY-1:0] valid_q;
   logic [PIX_W-1:0]      pixel_q [FILL_DELAY];
   logic [GRP_W-1:0]      group_q [FILL_DELAY];
   logic                  pending;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         valid_q <= '0;
         for (int i = 0; i < int'(FILL_DELAY); i++) begin
            pixel_q[i] <= '0;
            group_q[i] <= '0;
         end
      end else begin
         valid_q[0] <= valid_i;
         pixel_q[0] <= pixel_i;
         group_q[0] <= group_i;
         for (int i = 1; i < int'(FILL_DELAY); i++) begin
            valid_q[i] <= valid_q[i-1];
            pixel_q[i] <= pixel_q[i-1];
            group_q[i] <= group_q[i-1];
         end
      end
   end

   // Empty means nothing will remain after the next edge: the output stage is excluded so
   // the drain can finish in the same cycle the last tag is presented.
   always_comb begin
      pending = valid_i;
      for (int i = 0; i < int'(FILL_DELAY) - 1; i++) begin
         pending = pending | valid_q[i];
      end
   end

   assign empty_o = ~pending;
   assign valid_o = valid_q[FILL_DELAY-1];
   assign pixel_o = valid_o ? pixel_q[FILL_DELAY-1] : '0;
   assign group_o = valid_o ? group_q[FILL_DELAY-1] : '0;

endmodule

// File: rtl/npu_conv_sequencer.sv
// Walks pixel -> output-group -> input-chunk for one conv layer pass, issuing RAM reads, MAC
// valids/adder_rst and a tagged out_valid once each window leaves the MAC pipeline.
module npu_conv_sequencer
   import npu_pkg::*;
#(
   parameter int unsigned PIXELS     = DEF_PIXELS,
   parameter int unsigned IN_CHUNKS  = DEF_IN_CHUNKS,
   parameter int unsigned OUT_GROUPS = DEF_OUT_GROUPS,
   parameter int unsigned FILL_DELAY = DEF_FILL_DELAY,
   parameter int unsigned FA_W       = DEF_FA_W,
   parameter int unsigned PA_W       = DEF_PA_W,
   parameter int unsigned PIX_W      = DEF_PIX_W,
   parameter int unsigned GRP_W      = DEF_GRP_W
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             start_i,
   input  logic             hold_i,
   output logic             busy_o,
   output logic             done_o,
   output logic             fmap_rd_en_o,
   output logic [FA_W-1:0]  fmap_rd_addr_o,
   output logic             param_rd_en_o,
   output logic [PA_W-1:0]  param_rd_addr_o,
   output logic             mac_in_valid_o,
   output logic             adder_rst_o,
   output logic             out_valid_o,
   output logic [PIX_W-1:0] out_pixel_o,
   output logic [GRP_W-1:0] out_group_o
);

   localparam int unsigned CH_W = clog2_min1(IN_CHUNKS);

   seq_state_e       state_q, state_d;
   logic [CH_W-1:0]  chunk_q, chunk_d;
   logic [GRP_W-1:0] group_q, group_d;
   logic [PIX_W-1:0] pixel_q, pixel_d;

   logic rd_en;
   logic chunk_last, group_last, pixel_last, final_rd;
   logic line_empty;

   logic             mac_valid_q;
   logic             adder_rst_q;
   logic             beat_last_q;
   logic [PIX_W-1:0] beat_pixel_q;
   logic [GRP_W-1:0] beat_group_q;

   assign chunk_last = (chunk_q == CH_W'(IN_CHUNKS - 1));
   assign group_last = (group_q == GRP_W'(OUT_GROUPS - 1));
   assign pixel_last = (pixel_q == PIX_W'(PIXELS - 1));
   assign final_rd   = chunk_last && group_last && pixel_last;

   always_comb begin
      state_d = state_q;
      chunk_d = chunk_q;
      group_d = group_q;
      pixel_d = pixel_q;
      rd_en   = 1'b0;
      done_o  = 1'b0;
      busy_o  = (state_q != StIdle);

      case (state_q)
         StIdle: begin
            if (start_i) begin
               state_d = StRun;
               chunk_d = '0;
               group_d = '0;
               pixel_d = '0;
            end
         end
         StRun: begin
            if (!hold_i) begin
               rd_en = 1'b1;
               if (final_rd) begin
                  state_d = StDrain;
                  chunk_d = '0;
                  group_d = '0;
                  pixel_d = '0;
               end else if (chunk_last) begin
                  chunk_d = '0;
                  if (group_last) begin
                     group_d = '0;
                     pixel_d = pixel_q + 1'b1;
                  end else begin
                     group_d = group_q + 1'b1;
                  end
               end else begin
                  chunk_d = chunk_q + 1'b1;
               end
            end
         end
         StDrain: begin
            if (line_empty) begin
               state_d = StDone;
            end
         end
         StDone: begin
            done_o  = 1'b1;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= StIdle;
         chunk_q <= '0;
         group_q <= '0;
         pixel_q <= '0;
      end else begin
         state_q <= state_d;
         chunk_q <= chunk_d;
         group_q <= group_d;
         pixel_q <= pixel_d;
      end
   end

   // RAM output is registered, so MAC-side strobes lag the read by one cycle.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         mac_valid_q  <= 1'b0;
         adder_rst_q  <= 1'b0;
         beat_last_q  <= 1'b0;
         beat_pixel_q <= '0;
         beat_group_q <= '0;
      end else begin
         mac_valid_q  <= rd_en;
         adder_rst_q  <= rd_en && (chunk_q == '0);
         beat_last_q  <= rd_en && chunk_last;
         beat_pixel_q <= pixel_q;
         beat_group_q <= group_q;
      end
   end

   assign fmap_rd_en_o    = rd_en;
   assign param_rd_en_o   = rd_en;
   assign fmap_rd_addr_o  = rd_en ? (FA_W'(pixel_q) * FA_W'(IN_CHUNKS) + FA_W'(chunk_q)) : '0;
   assign param_rd_addr_o = rd_en ? (PA_W'(group_q) * PA_W'(IN_CHUNKS) + PA_W'(chunk_q)) : '0;
   assign mac_in_valid_o  = mac_valid_q;
   assign adder_rst_o     = adder_rst_q;

   npu_tag_delay #(
      .FILL_DELAY (FILL_DELAY),
      .PIX_W      (PIX_W),
      .GRP_W      (GRP_W)
   ) u_tag_delay (
      .clk     (clk),
      .rstn    (rstn),
      .valid_i (beat_last_q),
      .pixel_i (beat_pixel_q),
      .group_i (beat_group_q),
      .valid_o (out_valid_o),
      .pixel_o (out_pixel_o),
      .group_o (out_group_o),
      .empty_o (line_empty)
   );

endmodule

// File: tb/tb_npu_conv_sequencer.sv
// Directed bench: small 2-pixel passes (plain, hold, stray starts, mid-pass reset), a
// FILL_DELAY=1 pass under toggling hold, and one full default-geometry pass.
module tb_npu_conv_sequencer;

   logic clk = 1'b0;
   logic rstn = 1'b0;
   logic start = 1'b0;
   logic start_d = 1'b0;
   logic hold = 1'b0;
   logic sel = 1'b0;
   int   cyc = 0;

   int n_checks = 0;
   int n_fail = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   logic start_s, start_f;
   assign start_s = start & ~sel;
   assign start_f = start & sel;

   // Small-geometry instances (s: FILL_DELAY=10, f: FILL_DELAY=1) and default instance (d)
   logic        s_busy, s_done, s_rd, s_prd, s_mv, s_ar, s_ov;
   logic [11:0] s_fa;
   logic [4:0]  s_pa;
   logic [9:0]  s_op;
   logic [2:0]  s_og;
   logic        f_busy, f_done, f_rd, f_prd, f_mv, f_ar, f_ov;
   logic [11:0] f_fa;
   logic [4:0]  f_pa;
   logic [9:0]  f_op;
   logic [2:0]  f_og;
   logic        d_busy, d_done, d_rd, d_prd, d_mv, d_ar, d_ov;
   logic [11:0] d_fa;
   logic [4:0]  d_pa;
   logic [9:0]  d_op;
   logic [2:0]  d_og;

   npu_conv_sequencer #(.PIXELS(2), .FILL_DELAY(10)) dut_s (
      .clk(clk), .rstn(rstn), .start_i(start_s), .hold_i(hold), .busy_o(s_busy),
      .done_o(s_done), .fmap_rd_en_o(s_rd), .fmap_rd_addr_o(s_fa), .param_rd_en_o(s_prd),
      .param_rd_addr_o(s_pa), .mac_in_valid_o(s_mv), .adder_rst_o(s_ar), .out_valid_o(s_ov),
      .out_pixel_o(s_op), .out_group_o(s_og)
   );

   npu_conv_sequencer #(.PIXELS(2), .FILL_DELAY(1)) dut_f (
      .clk(clk), .rstn(rstn), .start_i(start_f), .hold_i(hold), .busy_o(f_busy),
      .done_o(f_done), .fmap_rd_en_o(f_rd), .fmap_rd_addr_o(f_fa), .param_rd_en_o(f_prd),
      .param_rd_addr_o(f_pa), .mac_in_valid_o(f_mv), .adder_rst_o(f_ar), .out_valid_o(f_ov),
      .out_pixel_o(f_op), .out_group_o(f_og)
   );

   npu_conv_sequencer dut_d (
      .clk(clk), .rstn(rstn), .start_i(start_d), .hold_i(hold), .busy_o(d_busy),
      .done_o(d_done), .fmap_rd_en_o(d_rd), .fmap_rd_addr_o(d_fa), .param_rd_en_o(d_prd),
      .param_rd_addr_o(d_pa), .mac_in_valid_o(d_mv), .adder_rst_o(d_ar), .out_valid_o(d_ov),
      .out_pixel_o(d_op), .out_group_o(d_og)
   );

   logic        m_busy, m_done, m_rd, m_prd, m_ar, m_ov;
   logic [11:0] m_fa;
   logic [4:0]  m_pa;
   logic [9:0]  m_op;
   logic [2:0]  m_og;
   assign m_busy = sel ? f_busy : s_busy;
   assign m_done = sel ? f_done : s_done;
   assign m_rd   = sel ? f_rd : s_rd;
   assign m_prd  = sel ? f_prd : s_prd;
   assign m_ar   = sel ? f_ar : s_ar;
   assign m_ov   = sel ? f_ov : s_ov;
   assign m_fa   = sel ? f_fa : s_fa;
   assign m_pa   = sel ? f_pa : s_pa;
   assign m_op   = sel ? f_op : s_op;
   assign m_og   = sel ? f_og : s_og;

   // Event logs, only appended by the monitor; tests index from a snapshot base.
   int rd_cyc[$], fa_q[$], pa_q[$], prd_q[$], ar_cyc[$], ov_cyc[$], ovp[$], ovg[$];
   int done_q[$], bf_q[$];
   logic busy_prev = 1'b0;
   int d_rdn = 0, d_ovn = 0, d_donen = 0, d_last_fa = -1, d_last_p = -1, d_last_g = -1;
   int d_last_ov = -1, d_done_cyc = -1;

   always @(negedge clk) begin
      if (m_rd) begin
         rd_cyc.push_back(cyc);
         fa_q.push_back(int'(m_fa));
         pa_q.push_back(int'(m_pa));
         prd_q.push_back(int'(m_prd));
      end
      if (m_ar) ar_cyc.push_back(cyc);
      if (m_ov) begin
         ov_cyc.push_back(cyc);
         ovp.push_back(int'(m_op));
         ovg.push_back(int'(m_og));
      end
      if (m_done) done_q.push_back(cyc);
      if (busy_prev && !m_busy) bf_q.push_back(cyc);
      busy_prev <= m_busy;
      if (d_rd) begin
         d_rdn     <= d_rdn + 1;
         d_last_fa <= int'(d_fa);
      end
      if (d_ov) begin
         d_ovn     <= d_ovn + 1;
         d_last_p  <= int'(d_op);
         d_last_g  <= int'(d_og);
         d_last_ov <= cyc;
      end
      if (d_done) begin
         d_donen    <= d_donen + 1;
         d_done_cyc <= cyc;
      end
   end

   int rb, ab, ob, db, bb;

   task automatic check_eq(input string tag, input longint obs, input longint exp);
      n_checks++;
      if (obs != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic snap();
      rb = rd_cyc.size();
      ab = ar_cyc.size();
      ob = ov_cyc.size();
      db = done_q.size();
      bb = bf_q.size();
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Returns T, the cycle during which start was high; leaves the bench in cycle T+1.
   task automatic pulse_start(output int t);
      tick(1);
      t = cyc;
      start = 1'b1;
      tick(1);
      start = 1'b0;
   endtask

   // Expected read cycle of beat i with an optional hold of hl cycles starting before beat ha.
   function automatic int rc(input int t, input int i, input int ha, input int hl);
      return t + 1 + i + ((i >= ha) ? hl : 0);
   endfunction

   task automatic check_small_pass(input string nm, input int t, input int ha, input int hl);
      check_eq({nm, " reads"}, rd_cyc.size() - rb, 40);
      for (int i = 0; i < 40; i++) begin
         if (rb + i < rd_cyc.size()) begin
            check_eq($sformatf("%s rd_cyc[%0d]", nm, i), rd_cyc[rb+i], rc(t, i, ha, hl));
            check_eq($sformatf("%s fa[%0d]", nm, i), fa_q[rb+i], (i / 20) * 4 + i % 4);
            check_eq($sformatf("%s pa[%0d]", nm, i), pa_q[rb+i], i % 20);
         end
      end
      check_eq({nm, " param_rd_en"}, prd_q[rb], 1);
      check_eq({nm, " adder_rst count"}, ar_cyc.size() - ab, 10);
      for (int k = 0; k < 10; k++) begin
         if (ab + k < ar_cyc.size()) begin
            check_eq($sformatf("%s ar_cyc[%0d]", nm, k), ar_cyc[ab+k], rc(t, 4*k, ha, hl) + 1);
         end
      end
      check_eq({nm, " out_valid count"}, ov_cyc.size() - ob, 10);
      for (int k = 0; k < 10; k++) begin
         if (ob + k < ov_cyc.size()) begin
            check_eq($sformatf("%s ov_cyc[%0d]", nm, k), ov_cyc[ob+k],
                     rc(t, 4*k + 3, ha, hl) + 11);
            check_eq($sformatf("%s ov_pix[%0d]", nm, k), ovp[ob+k], k / 5);
            check_eq($sformatf("%s ov_grp[%0d]", nm, k), ovg[ob+k], k % 5);
         end
      end
      check_eq({nm, " done count"}, done_q.size() - db, 1);
      if (db < done_q.size()) check_eq({nm, " done cyc"}, done_q[db], rc(t, 39, ha, hl) + 12);
      if (bb < bf_q.size()) check_eq({nm, " busy fall"}, bf_q[bb], rc(t, 39, ha, hl) + 13);
      else check_eq({nm, " busy fall seen"}, 0, 1);
   endtask

   initial begin
      int t;

      tick(3);
      check_eq("reset busy", s_busy, 0);
      check_eq("reset rd_en", s_rd, 0);
      check_eq("reset out_valid", s_ov, 0);
      rstn = 1'b1;
      tick(2);
      check_eq("idle busy", s_busy, 0);
      check_eq("idle done", s_done, 0);
      check_eq("idle mac_in_valid", s_mv, 0);
      check_eq("idle adder_rst", s_ar, 0);
      check_eq("idle default busy", d_busy, 0);

      // Plain pass, with stray starts at T+5 and on the done cycle T+52.
      snap();
      pulse_start(t);
      check_eq("busy at T+1", s_busy, 1);
      check_eq("rd_en at T+1", s_rd, 1);
      tick(4);
      start = 1'b1;
      tick(1);
      start = 1'b0;
      tick(46);
      check_eq("done at T+52", s_done, 1);
      start = 1'b1;
      tick(1);
      start = 1'b0;
      tick(25);
      check_small_pass("plain", t, 40, 0);

      // Hold for 3 cycles at chunk 2 of (pixel 0, group 1), i.e. before beat 6.
      snap();
      pulse_start(t);
      tick(6);
      hold = 1'b1;
      tick(3);
      hold = 1'b0;
      tick(60);
      check_small_pass("hold", t, 6, 3);

      // Reset in the middle of RUN, then a fresh pass.
      pulse_start(t);
      tick(9);
      rstn = 1'b0;
      tick(1);
      check_eq("rst busy", s_busy, 0);
      check_eq("rst rd_en", s_rd, 0);
      check_eq("rst mac_in_valid", s_mv, 0);
      check_eq("rst adder_rst", s_ar, 0);
      check_eq("rst out_valid", s_ov, 0);
      snap();
      tick(1);
      rstn = 1'b1;
      tick(30);
      check_eq("post-rst reads", rd_cyc.size() - rb, 0);
      check_eq("post-rst out_valid", ov_cyc.size() - ob, 0);
      check_eq("post-rst done", done_q.size() - db, 0);
      snap();
      pulse_start(t);
      tick(60);
      check_small_pass("restart", t, 40, 0);

      // FILL_DELAY=1 with hold toggling every cycle.
      sel = 1'b1;
      tick(1);
      snap();
      pulse_start(t);
      for (int i = 0; i < 150; i++) begin
         hold = ~hold;
         tick(1);
      end
      hold = 1'b0;
      tick(5);
      check_eq("fd1 reads", rd_cyc.size() - rb, 40);
      check_eq("fd1 out_valid count", ov_cyc.size() - ob, 10);
      check_eq("fd1 adder_rst count", ar_cyc.size() - ab, 10);
      check_eq("fd1 done count", done_q.size() - db, 1);
      if (rd_cyc.size() - rb == 40) begin
         check_eq("fd1 read spread", (rd_cyc[rb+39] - rd_cyc[rb] >= 70) ? 1 : 0, 1);
         for (int i = 0; i < 40; i++) begin
            check_eq($sformatf("fd1 fa[%0d]", i), fa_q[rb+i], (i / 20) * 4 + i % 4);
            check_eq($sformatf("fd1 pa[%0d]", i), pa_q[rb+i], i % 20);
         end
         for (int k = 0; k < 10; k++) begin
            if (ob + k < ov_cyc.size()) begin
               check_eq($sformatf("fd1 ov_cyc[%0d]", k), ov_cyc[ob+k], rd_cyc[rb+4*k+3] + 2);
               check_eq($sformatf("fd1 ov_pix[%0d]", k), ovp[ob+k], k / 5);
               check_eq($sformatf("fd1 ov_grp[%0d]", k), ovg[ob+k], k % 5);
            end
            if (ab + k < ar_cyc.size()) begin
               check_eq($sformatf("fd1 ar_cyc[%0d]", k), ar_cyc[ab+k], rd_cyc[rb+4*k] + 1);
            end
         end
      end
      if (ov_cyc.size() - ob == 10 && done_q.size() > db) begin
         check_eq("fd1 done after last out", done_q[db] - ov_cyc[ob+9], 1);
      end
      sel = 1'b0;

      // Full default geometry pass.
      tick(1);
      start_d = 1'b1;
      tick(1);
      start_d = 1'b0;
      tick(20480 + 40);
      check_eq("def reads", d_rdn, 20480);
      check_eq("def out_valid count", d_ovn, 5120);
      check_eq("def last fa", d_last_fa, 4095);
      check_eq("def last pixel", d_last_p, 1023);
      check_eq("def last group", d_last_g, 4);
      check_eq("def done count", d_donen, 1);
      check_eq("def done after last out", d_done_cyc - d_last_ov, 1);
      check_eq("def busy end", d_busy, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
